// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and lane-mask helper for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  function automatic logic [3:0] lane_mask(lsu_size_e size, logic [1:0] off);
    logic [3:0] m;
    case (size)
      BYTE:    m = 4'b0001 << off;
      HALF:    m = 4'b0011 << off;
      WORD:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane alignment: store shift/mask, load extract/extend, misalign check
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  lsu_size_e   sz;
  logic [31:0] w;

  assign sz       = lsu_size_e'(size);
  assign wmask    = lane_mask(sz, off);
  assign wdata_sh = wdata << {off, 3'b000};
  assign w        = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext  = w;
    misaligned = 1'b0;
    case (sz)
      BYTE: rdata_ext = {{24{~is_unsigned & w[7]}}, w[7:0]};
      HALF: begin
        rdata_ext  = {{16{~is_unsigned & w[15]}}, w[15:0]};
        misaligned = off[0];
      end
      WORD: misaligned = (off != 2'b00);
      ILL:  misaligned = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: request FSM and capture registers driving the memory data port
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        idle;
  logic [1:0]  a_size, a_off;
  logic [3:0]  a_wmask;
  logic [31:0] a_wdata, a_rdata;
  logic        a_mis;

  // In IDLE the aligner judges the incoming request; afterwards it works on the captured one.
  assign idle   = (state_q == IDLE);
  assign a_size = idle ? req_size : size_q;
  assign a_off  = idle ? req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .size        (a_size),
    .off         (a_off),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .wmask       (a_wmask),
    .wdata_sh    (a_wdata),
    .rdata_ext   (a_rdata),
    .misaligned  (a_mis)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wen_d   = req_wen;
        size_d  = req_size;
        uns_d   = req_unsigned;
        wdata_d = req_wdata;
        rdata_d = 32'h0;
        err_d   = a_mis;
        state_d = a_mis ? RESP : REQ;
      end
      REQ:  if (mem_ready) state_d = WAIT;
      WAIT: if (mem_rvalid) begin
        rdata_d = wen_q ? 32'h0 : a_rdata;
        state_d = RESP;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = idle & ~rst;
  assign mem_valid  = (state_q == REQ);
  assign mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wen    = mem_valid & wen_q;
  assign mem_wmask  = mem_valid ? {4'b0000, a_wmask} : 8'h00;
  assign mem_wdata  = mem_valid ? a_wdata : 32'h0;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for the load/store unit
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk); #1;
    req_valid    = 1'b0;
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input logic [31:0] rd,
                         input logic [7:0] exp_mask, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input int mstall, input int rstall);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    drive_req(addr, wen, size, uns, wdata);
    for (int i = 0; i <= mstall; i++) begin
      check("mem_valid", 32'(mem_valid), 32'd1);
      check("mem_addr", mem_addr, {addr[31:2], 2'b00});
      check("mem_wen", 32'(mem_wen), 32'(wen));
      check("mem_wmask", 32'(mem_wmask), 32'(exp_mask));
      check("mem_wdata", mem_wdata, exp_wdata);
      check("req_ready_busy", 32'(req_ready), 32'd0);
      mem_ready = (i == mstall);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    check("mem_valid_wait", 32'(mem_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int i = 0; i <= rstall; i++) begin
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_rdata", resp_rdata, exp_rdata);
      check("resp_err", 32'(resp_err), 32'd0);
      check("req_ready_resp", 32'(req_ready), 32'd0);
      resp_ready = (i == rstall);
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    check("req_ready_back", 32'(req_ready), 32'd1);
    check("resp_valid_done", 32'(resp_valid), 32'd0);
  endtask

  task automatic run_err(input logic [31:0] addr, input logic [1:0] size);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    drive_req(addr, 1'b0, size, 1'b0, 32'h0);
    check("err_resp_valid", 32'(resp_valid), 32'd1);
    check("err_resp_err", 32'(resp_err), 32'd1);
    check("err_rdata", resp_rdata, 32'h0);
    check("err_mem_valid", 32'(mem_valid), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("err_mem_valid_after", 32'(mem_valid), 32'd0);
    check("err_req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; req_wen = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;

    //      addr          wen   size   uns   wdata         mem_rdata     mask   mem_wdata     resp_rdata    ms rs
    run_txn(32'h80000003, 1'b1, 2'b00, 1'b0, 32'h000000AB, 32'h00000000, 8'h08, 32'hAB000000, 32'h00000000, 0, 0);
    run_txn(32'h80000001, 1'b0, 2'b00, 1'b0, 32'h00000000, 32'h123480FF, 8'h02, 32'h00000000, 32'hFFFFFF80, 0, 0);
    run_txn(32'h80000001, 1'b0, 2'b00, 1'b1, 32'h00000000, 32'h123480FF, 8'h02, 32'h00000000, 32'h00000080, 0, 0);
    run_txn(32'h80000002, 1'b0, 2'b01, 1'b0, 32'h00000000, 32'h80010000, 8'h0C, 32'h00000000, 32'hFFFF8001, 0, 0);
    run_txn(32'h80000002, 1'b0, 2'b01, 1'b1, 32'h00000000, 32'h80010000, 8'h0C, 32'h00000000, 32'h00008001, 0, 0);
    run_txn(32'h80000002, 1'b1, 2'b01, 1'b0, 32'h00001234, 32'h00000000, 8'h0C, 32'h12340000, 32'h00000000, 0, 0);
    run_txn(32'h80000004, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 8'h0F, 32'hDEADBEEF, 32'h00000000, 3, 0);
    run_txn(32'h80000008, 1'b0, 2'b10, 1'b0, 32'h00000000, 32'hCAFEF00D, 8'h0F, 32'h00000000, 32'hCAFEF00D, 0, 2);

    run_err(32'h80000002, 2'b10);
    run_err(32'h80000000, 2'b11);
    run_err(32'h80000001, 2'b01);

    // Reset while waiting on memory: everything drops at once and the late completion is ignored.
    drive_req(32'h80000000, 1'b0, 2'b10, 1'b0, 32'h0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("wait_mem_valid", 32'(mem_valid), 32'd0);
    check("wait_resp_valid", 32'(resp_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_mem_valid", 32'(mem_valid), 32'd0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_mem_wen", 32'(mem_wen), 32'd0);
    check("arst_mem_wmask", 32'(mem_wmask), 32'd0);
    check("arst_mem_wdata", mem_wdata, 32'h0);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_resp_rdata", resp_rdata, 32'h0);
    check("arst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel_req_ready", 32'(req_ready), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("late_rvalid_resp", 32'(resp_valid), 32'd0);
      check("late_rvalid_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator that drives the unified memory's data-access port. It accepts one load or store per transaction from the execute stage and issues a word-aligned, byte-masked request to memory. On loads it extracts and sign/zero-extends the addressed bytes; stores are shifted into the correct byte lanes. Misaligned and illegal requests are rejected without touching memory. Valid/ready handshakes on both sides let memory latency grow later without changing the core.

## Interface
- No parameters (XLEN fixed at 32).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: LSU can accept.
- `req_addr` in 32: byte address.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend load (lbu/lhu).
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: core accepts response.
- `resp_rdata` out 32: extended load data; 0 for stores/errors.
- `resp_err` out 1: misaligned/illegal.
- `mem_valid` out 1: memory request valid.
- `mem_ready` in 1: memory accepts request.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_wen` out 1: write enable.
- `mem_wmask` out 8: byte-lane mask; bits [7:4] always 0.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rvalid` in 1: memory completion (loads and stores).
- `mem_rdata` in 32: full read word.

## Operation
- FSM states:
  - IDLE: `req_ready=1`. On `req_valid`, capture addr/wen/size/unsigned/wdata. Misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size=11 goes to RESP with err=1. Otherwise go to REQ.
  - REQ: `mem_valid=1`, all mem_* outputs held stable. On `mem_ready`, go to WAIT.
  - WAIT: on `mem_rvalid`, register the extracted data (loads) and go to RESP. `mem_rvalid` is ignored outside WAIT.
  - RESP: `resp_valid=1`, outputs held. On `resp_ready`, go to IDLE.
- `off = addr[1:0]`.
- `mem_wmask`: byte `4'b0001<<off`; half `4'b0011<<off`; word `4'b1111`. The mask is driven for loads too; memory ignores it.
- `mem_wdata = req_wdata << (8*off)`.
- Load extract: `w = mem_rdata >> (8*off)`; byte w[7:0], half w[15:0]. Sign-extend unless `req_unsigned`. Word is passed through.
- `mem_wen`, `mem_wmask` and `mem_wdata` are 0 whenever `mem_valid=0`.
- Reset (any state): state→IDLE, all outputs 0 except `req_ready=1` once `rst` deasserts. An in-flight memory transaction is abandoned; memory is reset in the same domain.
- A new request is never accepted while RESP is pending; there is one outstanding transaction maximum.

## Timing
- Accept at edge N. Then `mem_valid` is high in cycle N+1.
- With `mem_ready` in N+1 and `mem_rvalid` in N+2, `resp_valid` is high in N+3. Minimum load/store latency is 3 cycles.
- Error path: accept at N, `resp_valid=1 resp_err=1` in N+1, and `mem_valid` never rises.
- The combinational memory is wrapped to give `mem_ready=1` always and `mem_rvalid` one cycle after acceptance.
- Back-to-back: `req_ready` returns the cycle after the `resp_valid&resp_ready` edge.

## Structure
- `lsu_pkg` holds:
  - `lsu_size_e` (BYTE/HALF/WORD/ILL)
  - `lsu_state_e` (IDLE/REQ/WAIT/RESP)
  - function `lane_mask(size, off)` returning 4 bits
- `lsu_align` sub-module is purely combinational. It contains store shift + mask, load extract/extend, and the misalign check. The FSM and capture registers live in `lsu`.

## Test plan
- Store byte: addr 0x80000003, wdata 0x000000AB → `mem_addr` 0x80000000, `mem_wmask` 0x08, `mem_wdata` 0xAB000000. Then `resp_valid` with rdata 0, err 0.
- Load byte: `mem_rdata` 0x123480FF, addr 0x80000001.
  - signed → 0xFFFFFF80
  - `req_unsigned=1` → 0x00000080
- Load half: addr 0x80000002, `mem_rdata` 0x80010000.
  - signed → 0xFFFF8001
  - unsigned → 0x00008001
- Misaligned word at 0x80000002 and size=11 → `resp_err=1` one cycle after accept, `mem_valid` stays 0.
- Backpressure:
  - Hold `mem_ready=0` for 3 cycles → `mem_valid` and all mem_* outputs stable.
  - Hold `resp_ready=0` for 2 cycles → `resp_valid` and `resp_rdata` stable, `req_ready=0`.
- Assert `rst` during WAIT → all outputs 0 immediately (asynchronous). After release, `req_ready=1`; a late `mem_rvalid` produces no response.
